// File: rtl/exu_bjp_resolve.sv
// Resolves branch/jump outcome and target against the IFU prediction; optional perf counters under EXU_BJP_PERF_EN.
// Latency: results and flush request registered one cycle after accept. Backpressure: i_ready drops while a redirect
// is outstanding or an undrained result is held (o_valid & ~o_ready).
module exu_bjp_resolve #(
    parameter int XLEN_W     = 32,
    parameter int PC_W       = 32,
    parameter int PERF_CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_jal,
    input  logic              i_jalr,
    input  logic              i_bxx,
    input  logic [2:0]        i_funct3,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [XLEN_W-1:0] i_imm,
    input  logic [XLEN_W-1:0] i_rs1,
    input  logic [XLEN_W-1:0] i_rs2,
    input  logic              i_prdt_taken,
    input  logic [PC_W-1:0]   i_prdt_pc,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_taken,
    output logic              o_mispred,
    output logic [XLEN_W-1:0] o_link,
    output logic              flush_req,
    input  logic              flush_ack,
`ifdef EXU_BJP_PERF_EN
    output logic [PERF_CNT_W-1:0] perf_bjp_cnt,
    output logic [PERF_CNT_W-1:0] perf_mispred_cnt,
`endif
    output logic [PC_W-1:0]   flush_pc
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                o_valid_q, o_valid_d;
    logic                o_taken_q, o_taken_d;
    logic                o_mispred_q, o_mispred_d;
    logic [XLEN_W-1:0]   o_link_q, o_link_d;
    logic                flush_req_q, flush_req_d;
    logic [PC_W-1:0]     flush_pc_q, flush_pc_d;

    logic                accept;
    logic                is_jal, is_jalr, is_bxx;
    logic                bxx_taken, taken, mispred;
    logic [PC_W-1:0]     imm_pc, pc_plus4, pc_target, jalr_sum, target;

    // One-hot violations resolve with jal > jalr > bxx priority.
    assign is_jal  = i_jal;
    assign is_jalr = i_jalr & ~i_jal;
    assign is_bxx  = i_bxx & ~i_jal & ~i_jalr;

    assign imm_pc    = PC_W'($signed(i_imm));
    assign pc_plus4  = i_pc + PC_W'(4);
    assign pc_target = i_pc + imm_pc;
    assign jalr_sum  = PC_W'(i_rs1) + imm_pc;

    always_comb begin
        bxx_taken = 1'b0;
        case (i_funct3)
            3'b000:  bxx_taken = (i_rs1 == i_rs2);
            3'b001:  bxx_taken = (i_rs1 != i_rs2);
            3'b100:  bxx_taken = ($signed(i_rs1) <  $signed(i_rs2));
            3'b101:  bxx_taken = ($signed(i_rs1) >= $signed(i_rs2));
            3'b110:  bxx_taken = (i_rs1 <  i_rs2);
            3'b111:  bxx_taken = (i_rs1 >= i_rs2);
            default: bxx_taken = 1'b0;
        endcase
    end

    always_comb begin
        taken  = is_jal | is_jalr | (is_bxx & bxx_taken);
        target = is_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : pc_target;
        // An op with no type bits set never redirects, whatever IFU predicted.
        mispred = (is_jal | is_jalr | is_bxx) &
                  ((taken != i_prdt_taken) | (taken & (target != i_prdt_pc)));
    end

    assign i_ready = (state_q == ST_IDLE) & (~o_valid_q | o_ready);
    assign accept  = i_valid & i_ready;

    always_comb begin
        state_d     = state_q;
        o_valid_d   = o_valid_q;
        o_taken_d   = o_taken_q;
        o_mispred_d = o_mispred_q;
        o_link_d    = o_link_q;
        flush_req_d = flush_req_q;
        flush_pc_d  = flush_pc_q;

        if (accept) begin
            o_valid_d   = 1'b1;
            o_taken_d   = taken;
            o_mispred_d = mispred;
            o_link_d    = XLEN_W'(pc_plus4);
        end else if (o_ready) begin
            o_valid_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept && mispred) begin
                    state_d     = ST_FLUSH;
                    flush_req_d = 1'b1;
                    flush_pc_d  = taken ? target : pc_plus4;
                end
            end
            ST_FLUSH: begin
                if (flush_ack && flush_req_q) begin
                    state_d     = ST_IDLE;
                    flush_req_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            o_valid_q   <= 1'b0;
            o_taken_q   <= 1'b0;
            o_mispred_q <= 1'b0;
            o_link_q    <= '0;
            flush_req_q <= 1'b0;
            flush_pc_q  <= '0;
        end else begin
            state_q     <= state_d;
            o_valid_q   <= o_valid_d;
            o_taken_q   <= o_taken_d;
            o_mispred_q <= o_mispred_d;
            o_link_q    <= o_link_d;
            flush_req_q <= flush_req_d;
            flush_pc_q  <= flush_pc_d;
        end
    end

    assign o_valid   = o_valid_q;
    assign o_taken   = o_taken_q;
    assign o_mispred = o_mispred_q;
    assign o_link    = o_link_q;
    assign flush_req = flush_req_q;
    assign flush_pc  = flush_pc_q;

`ifdef EXU_BJP_PERF_EN
    logic [PERF_CNT_W-1:0] perf_bjp_cnt_q, perf_bjp_cnt_d;
    logic [PERF_CNT_W-1:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

    always_comb begin
        perf_bjp_cnt_d     = perf_bjp_cnt_q;
        perf_mispred_cnt_d = perf_mispred_cnt_q;
        if (accept) begin
            perf_bjp_cnt_d = perf_bjp_cnt_q + PERF_CNT_W'(1);
            if (mispred) begin
                perf_mispred_cnt_d = perf_mispred_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_bjp_cnt_q     <= '0;
            perf_mispred_cnt_q <= '0;
        end else begin
            perf_bjp_cnt_q     <= perf_bjp_cnt_d;
            perf_mispred_cnt_q <= perf_mispred_cnt_d;
        end
    end

    assign perf_bjp_cnt     = perf_bjp_cnt_q;
    assign perf_mispred_cnt = perf_mispred_cnt_q;
`endif

endmodule

// File: tb/tb_exu_bjp_resolve.sv
// Scoreboard bench for exu_bjp_resolve: directed cases plus randomized ops against a behavioural model.
module tb_exu_bjp_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_ready;
    logic        i_jal, i_jalr, i_bxx;
    logic [2:0]  i_funct3;
    logic [31:0] i_pc, i_imm, i_rs1, i_rs2, i_prdt_pc;
    logic        i_prdt_taken;
    logic        o_valid, o_ready, o_taken, o_mispred;
    logic [31:0] o_link;
    logic        flush_req, flush_ack;
    logic [31:0] flush_pc;
`ifdef EXU_BJP_PERF_EN
    logic [31:0] perf_bjp_cnt, perf_mispred_cnt;
`endif

    exu_bjp_resolve #(.XLEN_W(32), .PC_W(32), .PERF_CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
        .i_jal(i_jal), .i_jalr(i_jalr), .i_bxx(i_bxx), .i_funct3(i_funct3),
        .i_pc(i_pc), .i_imm(i_imm), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_prdt_taken(i_prdt_taken), .i_prdt_pc(i_prdt_pc),
        .o_valid(o_valid), .o_ready(o_ready), .o_taken(o_taken), .o_mispred(o_mispred),
        .o_link(o_link), .flush_req(flush_req), .flush_ack(flush_ack),
`ifdef EXU_BJP_PERF_EN
        .perf_bjp_cnt(perf_bjp_cnt), .perf_mispred_cnt(perf_mispred_cnt),
`endif
        .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          jal, jalr, bxx;
        bit [2:0]    f3;
        bit [31:0]   pc, imm, rs1, rs2;
        bit          pt;
        bit [31:0]   ppc;
    } op_t;

    typedef struct {
        bit          taken, mispred;
        bit [31:0]   link, fpc, tgt;
    } res_t;

    int   n_checks = 0;
    int   n_err    = 0;
    res_t sbq[$];

    // Model state of the handshakes as seen from outside the block.
    bit        flush_pend = 0;
    bit        oval_pend  = 0;
    bit [31:0] exp_fpc    = 0;
    int        exp_bjp    = 0;
    int        exp_mis    = 0;

    bit   rnd_ctl  = 1;
    bit   fix_ordy = 1;
    bit   fix_ack  = 0;
    op_t  cur_op;
    bit   cur_use_exp = 0;
    res_t cur_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input op_t o);
        res_t r;
        bit   tk;
        bit [31:0] tg;
        tk = 0;
        tg = 0;
        r.link = o.pc + 32'd4;
        if (o.jal) begin
            tk = 1;
            tg = o.pc + o.imm;
        end else if (o.jalr) begin
            tk = 1;
            tg = (o.rs1 + o.imm) & ~32'd1;
        end else if (o.bxx) begin
            tg = o.pc + o.imm;
            case (o.f3)
                3'd0: tk = (o.rs1 == o.rs2);
                3'd1: tk = (o.rs1 != o.rs2);
                3'd4: tk = ($signed(o.rs1) <  $signed(o.rs2));
                3'd5: tk = ($signed(o.rs1) >= $signed(o.rs2));
                3'd6: tk = (o.rs1 <  o.rs2);
                3'd7: tk = (o.rs1 >= o.rs2);
                default: tk = 0;
            endcase
        end
        r.taken   = tk;
        r.tgt     = tg;
        r.mispred = (o.jal || o.jalr || o.bxx) && ((tk != o.pt) || (tk && (tg != o.ppc)));
        r.fpc     = tk ? tg : r.link;
        return r;
    endfunction

    function automatic op_t mkop(input bit jal, input bit jalr, input bit bxx, input bit [2:0] f3,
                                 input bit [31:0] pc, input bit [31:0] imm, input bit [31:0] rs1,
                                 input bit [31:0] rs2, input bit pt, input bit [31:0] ppc);
        op_t o;
        o.jal = jal; o.jalr = jalr; o.bxx = bxx; o.f3 = f3;
        o.pc = pc; o.imm = imm; o.rs1 = rs1; o.rs2 = rs2; o.pt = pt; o.ppc = ppc;
        return o;
    endfunction

    function automatic res_t mkres(input bit t, input bit m, input bit [31:0] l, input bit [31:0] f);
        res_t r;
        r.taken = t; r.mispred = m; r.link = l; r.fpc = f; r.tgt = 0;
        return r;
    endfunction

    // Pre-edge sample: check block-level state against the model, then advance the model.
    task automatic sample(output bit acc);
        bit   er;
        res_t r;
        er = !flush_pend && (!oval_pend || o_ready);
        chk("i_ready", i_ready, er);
        chk("flush_req", flush_req, flush_pend);
        chk("o_valid", o_valid, oval_pend);
        if (flush_pend) chk("flush_pc", flush_pc, exp_fpc);
`ifdef EXU_BJP_PERF_EN
        chk("perf_bjp_cnt", perf_bjp_cnt, exp_bjp);
        chk("perf_mispred_cnt", perf_mispred_cnt, exp_mis);
`endif
        acc = i_valid && er;
        if (flush_pend && flush_ack) flush_pend = 0;
        if (acc) begin
            r = cur_use_exp ? cur_exp : model(cur_op);
            sbq.push_back(r);
            oval_pend = 1;
            exp_bjp++;
            if (r.mispred) begin
                flush_pend = 1;
                exp_fpc    = r.fpc;
                exp_mis++;
            end
        end else if (o_ready) begin
            oval_pend = 0;
        end
    endtask

    task automatic tick(output bit acc);
        if (rnd_ctl) begin
            o_ready   = ($urandom_range(0, 9) < 7);
            flush_ack = ($urandom_range(0, 9) < 3);
        end else begin
            o_ready   = fix_ordy;
            flush_ack = fix_ack;
        end
        #4;
        sample(acc);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        i_valid = 0;
        for (int k = 0; k < n; k++) tick(acc);
    endtask

    task automatic issue(input op_t o, input bit use_exp, input res_t e);
        bit acc;
        acc = 0;
        cur_op = o; cur_use_exp = use_exp; cur_exp = e;
        i_jal = o.jal; i_jalr = o.jalr; i_bxx = o.bxx; i_funct3 = o.f3;
        i_pc = o.pc; i_imm = o.imm; i_rs1 = o.rs1; i_rs2 = o.rs2;
        i_prdt_taken = o.pt; i_prdt_pc = o.ppc;
        i_valid = 1;
        for (int k = 0; k < 100 && !acc; k++) tick(acc);
        i_valid = 0;
        if (!acc) begin
            n_checks++;
            n_err++;
            $display("FAIL issue_timeout: op at pc 0x%0h not accepted within 100 cycles", o.pc);
        end
    endtask

    task automatic drain();
        rnd_ctl = 0; fix_ordy = 1; fix_ack = 1;
        idle(3);
        rnd_ctl = 1;
    endtask

    // Monitor: pops one expectation per completed output handshake.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_o_valid: got o_valid=1 expected empty scoreboard");
                end else begin
                    e = sbq.pop_front();
                    chk("o_taken", o_taken, e.taken);
                    chk("o_mispred", o_mispred, e.mispred);
                    chk("o_link", o_link, e.link);
                end
            end
        end
    end

    initial begin
        op_t  o;
        res_t r, dummy;
        int   kind;
        dummy = mkres(0, 0, 0, 0);
        rst_n = 0; i_valid = 0; o_ready = 0; flush_ack = 0;
        i_jal = 0; i_jalr = 0; i_bxx = 0; i_funct3 = 0;
        i_pc = 0; i_imm = 0; i_rs1 = 0; i_rs2 = 0; i_prdt_taken = 0; i_prdt_pc = 0;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_o_valid", o_valid, 0);
        chk("reset_flush_req", flush_req, 0);
        chk("reset_o_taken", o_taken, 0);
        chk("reset_o_mispred", o_mispred, 0);
        chk("reset_o_link", o_link, 0);
        chk("reset_flush_pc", flush_pc, 0);
        @(negedge clk);
        rst_n = 1;

        // Directed cases with hand-derived expectations.
        issue(mkop(0,0,1,3'd0,32'h100,32'hFFFF_FFF8,5,5,1,32'h0F8), 1, mkres(1,0,32'h104,0));
        issue(mkop(0,0,1,3'd1,32'h200,32'h40,3,3,0,0),             1, mkres(0,0,32'h204,0));
        issue(mkop(0,0,1,3'd1,32'h200,32'h40,3,4,0,0),             1, mkres(1,1,32'h204,32'h240));
        issue(mkop(0,1,0,3'd0,32'h300,32'h4,32'h1003,0,1,32'h1006), 1, mkres(1,0,32'h304,0));
        issue(mkop(0,1,0,3'd0,32'h300,32'h4,32'h1003,0,1,32'h1000), 1, mkres(1,1,32'h304,32'h1006));
        issue(mkop(0,0,1,3'd4,32'h400,32'h10,32'hFFFF_FFFF,1,1,32'h410), 1, mkres(1,0,32'h404,0));
        issue(mkop(0,0,1,3'd6,32'h400,32'h10,32'hFFFF_FFFF,1,1,32'h410), 1, mkres(0,1,32'h404,32'h404));
        issue(mkop(0,0,0,3'd0,32'h440,32'h10,0,0,1,32'h999),       1, mkres(0,0,32'h444,0));
        issue(mkop(1,1,1,3'd2,32'h480,32'h20,32'h7,32'h7,1,32'h4A0), 1, mkres(1,0,32'h484,0));
        issue(mkop(0,0,1,3'd2,32'h4C0,32'h20,1,1,1,32'h4E0),       1, mkres(0,1,32'h4C4,32'h4C4));

        // Redirect held unacknowledged for five cycles.
        drain();
        rnd_ctl = 0; fix_ordy = 1; fix_ack = 0;
        issue(mkop(1,0,0,3'd0,32'h500,32'h20,0,0,0,0), 1, mkres(1,1,32'h504,32'h520));
        idle(5);
        fix_ack = 1;
        idle(1);
        fix_ack = 0;
        idle(2);

        // Reset while a redirect and an undrained result are both outstanding.
        fix_ordy = 0; fix_ack = 0;
        issue(mkop(0,0,1,3'd0,32'h600,32'h8,1,1,0,0), 1, mkres(1,1,32'h604,32'h608));
        idle(1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        sbq.delete();
        flush_pend = 0; oval_pend = 0; exp_bjp = 0; exp_mis = 0;
        #4;
        chk("rst_mid_o_valid", o_valid, 0);
        chk("rst_mid_flush_req", flush_req, 0);
        chk("rst_mid_i_ready", i_ready, 1);
        chk("rst_mid_o_link", o_link, 0);
        @(negedge clk);
        rnd_ctl = 1;
        issue(mkop(0,0,1,3'd5,32'h700,32'h30,2,2,1,32'h730), 1, mkres(1,0,32'h704,0));
        issue(mkop(1,0,0,3'd0,32'h740,32'h10,0,0,1,32'h750), 1, mkres(1,0,32'h744,0));
        issue(mkop(0,0,1,3'd7,32'h780,32'h10,0,1,1,32'h790), 1, mkres(0,1,32'h784,32'h784));
        drain();

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            o = mkop(kind < 2, kind >= 2 && kind < 4, kind >= 4 && kind < 9,
                     3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom, 1'($urandom), $urandom);
            if (kind == 9) begin
                o.jal = 1'($urandom); o.jalr = 1'($urandom); o.bxx = 1'($urandom);
            end
            if ($urandom_range(0, 1) == 0) o.rs2 = o.rs1;
            if ($urandom_range(0, 2) == 0) o.imm = 32'($signed(12'($urandom)));
            r = model(o);
            if ($urandom_range(0, 1) == 0) o.ppc = r.tgt;
            issue(o, 0, dummy);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
